// File: rtl/rs_dec_ctrl_if.sv
// Handshake and strobe bundle between the RS(15,9) decoder controller, its
// symbol source, the decoder datapath stages and the result consumer.
interface rs_dec_ctrl_if #(
  parameter int WORD_WIDTH = 4
);
  logic                  sym_valid;
  logic [WORD_WIDTH-1:0] sym_data;
  logic                  sym_ready;
  logic                  syn_en;
  logic                  syn_first;
  logic [WORD_WIDTH-1:0] syn_data;
  logic                  syn_zero;
  logic                  kes_start;
  logic                  kes_done;
  logic [WORD_WIDTH-1:0] num_err;
  logic                  chien_start;
  logic                  chien_done;
  logic [WORD_WIDTH-1:0] chien_cnt;
  logic                  frn_en;
  logic                  frn_ready;
  logic                  res_valid;
  logic                  res_ready;
  logic [1:0]            res_status;
  logic [WORD_WIDTH-1:0] res_num_err;
  logic                  busy;

  modport master (
    input  sym_valid, sym_data, syn_zero, kes_done, num_err,
           chien_done, chien_cnt, frn_ready, res_ready,
    output sym_ready, syn_en, syn_first, syn_data, kes_start,
           chien_start, frn_en, res_valid, res_status, res_num_err, busy
  );

  modport slave (
    output sym_valid, sym_data, syn_zero, kes_done, num_err,
           chien_done, chien_cnt, frn_ready, res_ready,
    input  sym_ready, syn_en, syn_first, syn_data, kes_start,
           chien_start, frn_en, res_valid, res_status, res_num_err, busy
  );
endinterface

// File: rtl/rs_dec_ctrl.sv
// RS(15,9) decoder sequencing controller: loads a codeword into the syndrome
// stage, steps through key-equation, Chien and Forney, and reports a status.
module rs_dec_ctrl #(
  parameter int WORD_WIDTH = 4,
  parameter int N_NUM      = 15,
  parameter int T_NUM      = 3,
  parameter int TIMEOUT    = 31
) (
  input  logic          clk,
  input  logic          rst,
  rs_dec_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SYN    = 3'd2,
    S_KES    = 3'd3,
    S_CHIEN  = 3'd4,
    S_FORNEY = 3'd5,
    S_RESULT = 3'd6
  } state_e;

  localparam logic [3:0]            LAST_IDX = 4'(N_NUM - 1);
  localparam logic [4:0]            TMO_LAST = 5'(TIMEOUT - 1);
  localparam logic [WORD_WIDTH-1:0] T_MAX    = WORD_WIDTH'(T_NUM);
  localparam logic [WORD_WIDTH-1:0] ZERO_W   = {WORD_WIDTH{1'b0}};
  localparam logic [1:0] ST_CLEAN = 2'b00;
  localparam logic [1:0] ST_CORR  = 2'b01;
  localparam logic [1:0] ST_UNCOR = 2'b10;
  localparam logic [1:0] ST_TMO   = 2'b11;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [4:0]            tmr_q, tmr_d;
  logic                  sym_ready_q, sym_ready_d;
  logic                  syn_en_q, syn_en_d;
  logic                  syn_first_q, syn_first_d;
  logic [WORD_WIDTH-1:0] syn_data_q, syn_data_d;
  logic                  kes_start_q, kes_start_d;
  logic                  chien_start_q, chien_start_d;
  logic                  frn_en_q, frn_en_d;
  logic                  res_valid_q, res_valid_d;
  logic [1:0]            res_status_q, res_status_d;
  logic [WORD_WIDTH-1:0] res_num_err_q, res_num_err_d;
  logic [WORD_WIDTH-1:0] num_err_q, num_err_d;
  logic                  busy_q, busy_d;
  logic                  accept_s;
  logic                  done_ok_s;
  logic                  timeout_s;

  // State and output registers; reset clears every output including sym_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= 4'd0;
      tmr_q         <= 5'd0;
      sym_ready_q   <= 1'b0;
      syn_en_q      <= 1'b0;
      syn_first_q   <= 1'b0;
      syn_data_q    <= ZERO_W;
      kes_start_q   <= 1'b0;
      chien_start_q <= 1'b0;
      frn_en_q      <= 1'b0;
      res_valid_q   <= 1'b0;
      res_status_q  <= 2'b00;
      res_num_err_q <= ZERO_W;
      num_err_q     <= ZERO_W;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tmr_q         <= tmr_d;
      sym_ready_q   <= sym_ready_d;
      syn_en_q      <= syn_en_d;
      syn_first_q   <= syn_first_d;
      syn_data_q    <= syn_data_d;
      kes_start_q   <= kes_start_d;
      chien_start_q <= chien_start_d;
      frn_en_q      <= frn_en_d;
      res_valid_q   <= res_valid_d;
      res_status_q  <= res_status_d;
      res_num_err_q <= res_num_err_d;
      num_err_q     <= num_err_d;
      busy_q        <= busy_d;
    end
  end

  // Next-state and next-output logic; a done beats a timeout in the same cycle.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tmr_d         = 5'd0;
    sym_ready_d   = 1'b0;
    kes_start_d   = 1'b0;
    chien_start_d = 1'b0;
    frn_en_d      = 1'b0;
    res_valid_d   = res_valid_q;
    res_status_d  = res_status_q;
    res_num_err_d = res_num_err_q;
    num_err_d     = num_err_q;

    accept_s    = bus.sym_valid & sym_ready_q;
    done_ok_s   = (tmr_q >= 5'd2);
    timeout_s   = (tmr_q == TMO_LAST);
    syn_en_d    = accept_s;
    syn_first_d = accept_s & (cnt_q == 4'd0);
    syn_data_d  = accept_s ? bus.sym_data : syn_data_q;

    case (state_q)
      S_IDLE, S_LOAD: begin
        sym_ready_d = 1'b1;
        if (accept_s) begin
          if (cnt_q == LAST_IDX) begin
            cnt_d       = 4'd0;
            sym_ready_d = 1'b0;
            state_d     = S_SYN;
          end else begin
            cnt_d   = cnt_q + 4'd1;
            state_d = S_LOAD;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_SYN: begin
        tmr_d = tmr_q + 5'd1;
        // Syndromes settle one cycle after the last forwarded symbol.
        if (tmr_q == 5'd1) begin
          tmr_d = 5'd0;
          if (bus.syn_zero) begin
            state_d       = S_RESULT;
            res_valid_d   = 1'b1;
            res_status_d  = ST_CLEAN;
            res_num_err_d = ZERO_W;
          end else begin
            state_d     = S_KES;
            kes_start_d = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_KES: begin
        tmr_d = tmr_q + 5'd1;
        if (done_ok_s && bus.kes_done) begin
          tmr_d     = 5'd0;
          num_err_d = bus.num_err;
          if ((bus.num_err == ZERO_W) || (bus.num_err > T_MAX)) begin
            state_d       = S_RESULT;
            res_valid_d   = 1'b1;
            res_status_d  = ST_UNCOR;
            res_num_err_d = bus.num_err;
          end else begin
            state_d       = S_CHIEN;
            chien_start_d = 1'b1;
          end
        end else if (timeout_s) begin
          state_d       = S_RESULT;
          res_valid_d   = 1'b1;
          res_status_d  = ST_TMO;
          res_num_err_d = ZERO_W;
        end else begin
          state_d = state_q;
        end
      end
      S_CHIEN: begin
        tmr_d = tmr_q + 5'd1;
        if (done_ok_s && bus.chien_done) begin
          tmr_d = 5'd0;
          if (bus.chien_cnt != num_err_q) begin
            state_d       = S_RESULT;
            res_valid_d   = 1'b1;
            res_status_d  = ST_UNCOR;
            res_num_err_d = num_err_q;
          end else begin
            state_d  = S_FORNEY;
            frn_en_d = 1'b1;
          end
        end else if (timeout_s) begin
          state_d       = S_RESULT;
          res_valid_d   = 1'b1;
          res_status_d  = ST_TMO;
          res_num_err_d = ZERO_W;
        end else begin
          state_d = state_q;
        end
      end
      S_FORNEY: begin
        tmr_d = tmr_q + 5'd1;
        if (done_ok_s && bus.frn_ready) begin
          tmr_d         = 5'd0;
          state_d       = S_RESULT;
          res_valid_d   = 1'b1;
          res_status_d  = ST_CORR;
          res_num_err_d = num_err_q;
        end else if (timeout_s) begin
          state_d       = S_RESULT;
          res_valid_d   = 1'b1;
          res_status_d  = ST_TMO;
          res_num_err_d = ZERO_W;
        end else begin
          state_d = state_q;
        end
      end
      S_RESULT: begin
        if (bus.res_ready) begin
          state_d       = S_IDLE;
          res_valid_d   = 1'b0;
          res_status_d  = 2'b00;
          res_num_err_d = ZERO_W;
          sym_ready_d   = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign bus.sym_ready   = sym_ready_q;
  assign bus.syn_en      = syn_en_q;
  assign bus.syn_first   = syn_first_q;
  assign bus.syn_data    = syn_data_q;
  assign bus.kes_start   = kes_start_q;
  assign bus.chien_start = chien_start_q;
  assign bus.frn_en      = frn_en_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_status  = res_status_q;
  assign bus.res_num_err = res_num_err_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_rs_dec_ctrl.sv
// Directed bench for rs_dec_ctrl: behavioural stage models driven per cycle,
// hand-derived cycle offsets and status words checked through one task.
module tb_rs_dec_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   cyc, err_cnt, chk_cnt;
  int   n_kes, n_chien, n_frn, n_first;
  int   kes_cyc, chien_cyc, frn_cyc;
  int   kes_lat, chien_lat, frn_lat;
  int   tb_idx;
  bit   latch_chg;
  int   last, rc;

  rs_dec_ctrl_if #(.WORD_WIDTH(4)) bus ();

  rs_dec_ctrl #(.WORD_WIDTH(4), .N_NUM(15), .T_NUM(3), .TIMEOUT(31)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] outs();
    return {14'd0, bus.sym_ready, bus.syn_en, bus.syn_first, bus.syn_data,
            bus.kes_start, bus.chien_start, bus.frn_en, bus.res_valid,
            bus.res_status, bus.res_num_err, bus.busy};
  endfunction

  task automatic clr_stats();
    n_kes = 0; n_chien = 0; n_frn = 0; n_first = 0;
    kes_cyc = 0; chien_cyc = 0; frn_cyc = 0;
  endtask

  // One clock: checks symbol forwarding, then updates the stage models.
  task automatic tick();
    logic       acc_now, first_now;
    logic [3:0] d_now;
    acc_now   = bus.sym_valid && bus.sym_ready && !rst;
    d_now     = bus.sym_data;
    first_now = acc_now && (tb_idx == 0);
    @(posedge clk);
    if (rst) tb_idx = 0;
    else if (acc_now) tb_idx = (tb_idx == 14) ? 0 : tb_idx + 1;
    #1;
    cyc++;
    if (acc_now) begin
      chk("syn_en", 32'(bus.syn_en), 32'd1);
      chk("syn_first", 32'(bus.syn_first), 32'(first_now));
      chk("syn_data", 32'(bus.syn_data), 32'(d_now));
    end else if (bus.syn_en) begin
      chk("syn_en_spurious", 32'(bus.syn_en), 32'd0);
    end
    if (bus.syn_en && bus.syn_first) n_first++;
    if (bus.kes_start) begin n_kes++; kes_cyc = cyc; end
    if (bus.chien_start) begin n_chien++; chien_cyc = cyc; end
    if (bus.frn_en) begin n_frn++; frn_cyc = cyc; end
    bus.kes_done   = (n_kes > 0) && (cyc >= kes_cyc + kes_lat);
    bus.chien_done = (n_chien > 0) && (cyc >= chien_cyc + chien_lat);
    bus.frn_ready  = (n_frn == 0) || (cyc == frn_cyc) || (cyc >= frn_cyc + frn_lat);
    if (latch_chg && n_chien > 0) bus.num_err = 4'd7;
  endtask

  task automatic send(input int n, input bit keep, output int lst);
    int i, g, first;
    i = 0; g = 0; first = 0; lst = 0;
    while (i < n && g < 100) begin
      bus.sym_valid = 1'b1;
      bus.sym_data  = 4'((i * 7 + 3) % 16);
      if (bus.sym_ready) begin
        if (i == 0) first = cyc;
        lst = cyc;
        i++;
      end
      tick();
      g++;
    end
    bus.sym_valid = keep;
    chk("sym_accepted", 32'(i), 32'(n));
    chk("sym_rate", 32'(lst - first), 32'(n - 1));
  endtask

  task automatic wait_result(output int r);
    int g;
    g = 0;
    while (!bus.res_valid && g < 200) begin tick(); g++; end
    chk("res_valid_seen", 32'(bus.res_valid), 32'd1);
    r = cyc;
  endtask

  task automatic run_cw(input bit sz, input int ne, input int cc, input int kl,
                        input int cl, input int fl, input bit lc, input bit keep,
                        output int lst, output int r);
    clr_stats();
    bus.syn_zero  = sz;
    bus.num_err   = 4'(ne);
    bus.chien_cnt = 4'(cc);
    kes_lat = kl; chien_lat = cl; frn_lat = fl; latch_chg = lc;
    send(15, keep, lst);
    wait_result(r);
  endtask

  task automatic finish_cw();
    tick();
    chk("res_cleared", 32'(bus.res_valid), 32'd0);
    chk("rdy_after_res", 32'(bus.sym_ready), 32'd1);
  endtask

  initial begin
    cyc = 0; err_cnt = 0; chk_cnt = 0; tb_idx = 0; latch_chg = 1'b0;
    kes_lat = 2; chien_lat = 2; frn_lat = 2;
    clr_stats();
    rst = 1'b1;
    bus.sym_valid = 1'b0; bus.sym_data = 4'd0; bus.syn_zero = 1'b0;
    bus.kes_done = 1'b0; bus.num_err = 4'd0; bus.chien_done = 1'b0;
    bus.chien_cnt = 4'd0; bus.frn_ready = 1'b1; bus.res_ready = 1'b1;

    repeat (3) tick();
    chk("rst_outputs", outs(), 32'd0);
    rst = 1'b0;
    tick();
    chk("rdy_after_rst", 32'(bus.sym_ready), 32'd1);
    chk("busy_idle", 32'(bus.busy), 32'd0);

    // Reset in the middle of a codeword, then a clean codeword.
    clr_stats();
    bus.syn_zero = 1'b1;
    send(7, 1'b0, last);
    chk("busy_load", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick(); chk("rst_mid_a", outs(), 32'd0);
    tick(); chk("rst_mid_b", outs(), 32'd0);
    tick(); chk("rst_mid_c", outs(), 32'd0);
    rst = 1'b0;
    run_cw(1'b1, 0, 0, 2, 2, 2, 1'b0, 1'b0, last, rc);
    chk("clean_lat", 32'(rc), 32'(last + 3));
    chk("clean_status", 32'(bus.res_status), 32'd0);
    chk("clean_nerr", 32'(bus.res_num_err), 32'd0);
    chk("clean_first_once", 32'(n_first), 32'd1);
    chk("clean_no_kes", 32'(n_kes), 32'd0);
    finish_cw();

    // Corrected path with stale Forney ready and num_err changing after latch.
    run_cw(1'b0, 2, 2, 3, 2, 2, 1'b1, 1'b0, last, rc);
    chk("corr_kes_at", 32'(kes_cyc), 32'(last + 3));
    chk("corr_chien_at", 32'(chien_cyc), 32'(kes_cyc + 4));
    chk("corr_frn_at", 32'(frn_cyc), 32'(chien_cyc + 3));
    chk("corr_res_at", 32'(rc), 32'(frn_cyc + 3));
    chk("corr_n_kes", 32'(n_kes), 32'd1);
    chk("corr_n_chien", 32'(n_chien), 32'd1);
    chk("corr_n_frn", 32'(n_frn), 32'd1);
    chk("corr_status", 32'(bus.res_status), 32'd1);
    chk("corr_nerr", 32'(bus.res_num_err), 32'd2);
    finish_cw();

    // num_err above T.
    run_cw(1'b0, 4, 0, 2, 2, 2, 1'b0, 1'b0, last, rc);
    chk("unc4_res_at", 32'(rc), 32'(kes_cyc + 3));
    chk("unc4_status", 32'(bus.res_status), 32'd2);
    chk("unc4_nerr", 32'(bus.res_num_err), 32'd4);
    chk("unc4_no_chien", 32'(n_chien), 32'd0);
    chk("unc4_no_frn", 32'(n_frn), 32'd0);
    finish_cw();

    // num_err of zero with nonzero syndromes.
    run_cw(1'b0, 0, 0, 2, 2, 2, 1'b0, 1'b0, last, rc);
    chk("unc0_status", 32'(bus.res_status), 32'd2);
    chk("unc0_nerr", 32'(bus.res_num_err), 32'd0);
    chk("unc0_no_chien", 32'(n_chien), 32'd0);
    chk("unc0_no_frn", 32'(n_frn), 32'd0);
    finish_cw();

    // Chien root count disagrees with locator degree.
    run_cw(1'b0, 3, 2, 2, 2, 2, 1'b0, 1'b0, last, rc);
    chk("uncc_res_at", 32'(rc), 32'(chien_cyc + 3));
    chk("uncc_status", 32'(bus.res_status), 32'd2);
    chk("uncc_nerr", 32'(bus.res_num_err), 32'd3);
    chk("uncc_n_chien", 32'(n_chien), 32'd1);
    chk("uncc_no_frn", 32'(n_frn), 32'd0);
    finish_cw();

    // Key-equation stage never finishes.
    run_cw(1'b0, 2, 2, 1000, 2, 2, 1'b0, 1'b0, last, rc);
    chk("tmo_res_at", 32'(rc), 32'(kes_cyc + 31));
    chk("tmo_status", 32'(bus.res_status), 32'd3);
    chk("tmo_nerr", 32'(bus.res_num_err), 32'd0);
    chk("tmo_no_chien", 32'(n_chien), 32'd0);
    finish_cw();

    // Done arrives in the timeout cycle and wins.
    run_cw(1'b0, 1, 1, 30, 2, 2, 1'b0, 1'b0, last, rc);
    chk("edge_chien_at", 32'(chien_cyc), 32'(kes_cyc + 31));
    chk("edge_status", 32'(bus.res_status), 32'd1);
    chk("edge_nerr", 32'(bus.res_num_err), 32'd1);
    finish_cw();

    // Result back-pressure with the source still offering symbols.
    bus.res_ready = 1'b0;
    run_cw(1'b1, 0, 0, 2, 2, 2, 1'b0, 1'b1, last, rc);
    chk("bp_lat", 32'(rc), 32'(last + 3));
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_hold", 32'({bus.res_valid, bus.res_status, bus.res_num_err, bus.sym_ready}), 32'h80);
    end
    bus.res_ready = 1'b1;
    tick();
    chk("bp_res_cleared", 32'(bus.res_valid), 32'd0);
    chk("bp_rdy_next", 32'(bus.sym_ready), 32'd1);
    run_cw(1'b0, 1, 1, 2, 2, 2, 1'b0, 1'b0, last, rc);
    chk("bp_next_res_at", 32'(rc), 32'(last + 12));
    chk("bp_next_status", 32'(bus.res_status), 32'd1);
    chk("bp_next_nerr", 32'(bus.res_num_err), 32'd1);
    finish_cw();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/rs_dec_ctrl.md
# rs_dec_ctrl

Sequencing controller for the RS(15,9) decoder over GF(2^4). It accepts a 15-symbol codeword stream, feeds the syndrome stage, and launches the key-equation, Chien-search and Forney stages in turn, skipping stages when the result is already known. It ends each codeword with a status word on a valid/ready result port and sits between the input framer and the decoder datapath.

## Interface
- WORD_WIDTH, 4, symbol width in bits.
- N_NUM, 15, symbols per codeword.
- T_NUM, 3, correctable symbol errors.
- TIMEOUT, 31, maximum cycles to wait for any stage done; counter is 5 bits.
- clk  in  1  clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- sym_valid  in  1  upstream symbol valid.
- sym_data  in  WORD_WIDTH  upstream symbol.
- sym_ready  out  1  controller accepts a symbol.
- syn_en  out  1  forwarded-symbol strobe to the syndrome stage.
- syn_first  out  1  marks symbol 0; the syndrome stage clears its accumulators on it.
- syn_data  out  WORD_WIDTH  forwarded symbol.
- syn_zero  in  1  all syndromes zero.
- kes_start  out  1  key-equation start pulse.
- kes_done  in  1  key-equation done level.
- num_err  in  WORD_WIDTH  error-locator degree from the key-equation stage.
- chien_start  out  1  Chien-search start pulse.
- chien_done  in  1  Chien-search done level.
- chien_cnt  in  WORD_WIDTH  roots found.
- frn_en  out  1  Forney enable. One-cycle pulse; Forney acts on its 0→1 edge.
- frn_ready  in  1  Forney ready level.
- res_valid  out  1  result valid.
- res_ready  in  1  downstream accepts result.
- res_status  out  2  00 clean, 01 corrected, 10 uncorrectable, 11 timeout.
- res_num_err  out  WORD_WIDTH  num_err for status 01 or 10, else 0.
- busy  out  1  high in every state except IDLE.

## Operation
- Clock and reset: single clock `clk`. Synchronous active-high `rst` returns the FSM to IDLE.
- Outputs while `rst` is high: all outputs 0, including sym_ready, and the symbol counter is 0.
- States: IDLE, LOAD, SYN_WAIT, KES, CHIEN, FORNEY, RESULT.
- IDLE / LOAD:
  - sym_ready = 1, registered; it is 1 on the first cycle after rst is released.
  - Each sym_valid && sym_ready is an accepted symbol. The first accepted symbol moves IDLE→LOAD.
  - Each accepted symbol is forwarded on syn_en/syn_data one cycle later. syn_first is set for index 0.
  - A 4-bit counter counts symbols 0..N_NUM-1. When symbol 14 is accepted, the counter wraps to 0, sym_ready drops the next cycle, and the FSM goes to SYN_WAIT.
- SYN_WAIT: lasts exactly 2 cycles; syn_zero is sampled in the second cycle.
  - syn_zero = 1: status 00, go to RESULT.
  - syn_zero = 0: pulse kes_start, go to KES.
- Stage wait (applies to KES, CHIEN and FORNEY):
  - The done input is ignored in the start-pulse cycle and the following cycle, so a stale ready level is never taken. It is sampled from the 3rd cycle on.
  - A cycle counter, cleared on start, forces status 11 and RESULT if done has not been seen once the count reaches TIMEOUT.
- KES done:
  - num_err = 0 or num_err > T_NUM: status 10, go to RESULT.
  - Otherwise: pulse chien_start, go to CHIEN.
- CHIEN done:
  - chien_cnt ≠ num_err: status 10.
  - Otherwise: pulse frn_en, go to FORNEY.
- FORNEY done: status 01.
- num_err is latched when kes_done is taken; later changes on the input are ignored.
- RESULT:
  - res_valid, res_status and res_num_err are held stable until res_valid && res_ready.
  - On that handshake, outputs clear and the FSM returns to IDLE; sym_ready is 1 the next cycle.
- Priority:
  - A done and a timeout in the same cycle: done wins.
  - rst overrides everything, including mid-codeword or mid-stage. There is no partial result, and the next codeword starts at symbol 0.
- Start pulses (kes_start, chien_start, frn_en) are exactly one cycle and mutually exclusive.

## Timing
- Symbol throughput is one per cycle while sym_valid is held.
- Clean-codeword latency: last symbol accepted at cycle L, syn_en at L+1, syn_zero sampled at L+2, res_valid at L+3.
- Stage handoff:
  - A done sampled at cycle D gives the next start pulse at D+1, or res_valid at D+1.
  - Minimum per stage is 3 cycles from start to next action.
- Forney: frn_en at cycle F. frn_ready is earliest sampled at F+2, giving res_valid at F+3.
- No back-to-back overlap: a new codeword is accepted only after the result handshake.

## Test plan
- Reset: hold rst 3 cycles mid-LOAD after 7 symbols, then stream 15 symbols with syn_zero=1.
  - All outputs are 0 during reset.
  - The counter restarts at symbol 0, syn_first is seen once, and status 00 arrives exactly 3 cycles after the last symbol.
- Corrected path: syn_zero=0, num_err=2, chien_cnt=2, Forney model whose ready is stale 1 then goes 0/1.
  - kes_start, chien_start and frn_en each pulse once.
  - The stale frn_ready at cycle F is ignored; res_status=01, res_num_err=2 at F+3.
- Uncorrectable paths, each giving res_status=10 with no frn_en pulse:
  - num_err=4: no chien_start.
  - num_err=0: no chien_start.
  - num_err=3 with chien_cnt=2.
- Timeout: kes_done held 0.
  - res_status=11 exactly TIMEOUT cycles after kes_start.
  - A kes_done arriving in that same cycle instead yields chien_start.
- Back-pressure: hold res_ready=0 for 10 cycles while sym_valid=1.
  - Result fields stay stable and sym_ready stays 0.
  - After the handshake, sym_ready=1 next cycle and the next codeword decodes correctly.
